// File: rtl/iir_biquad_tdm_if.sv
// iir_biquad_tdm_if -- sample stream, coefficient load and clear bundle for
// iir_biquad_tdm.
//   data_i/ch_i/valid_i/ready_o : input sample handshake (channel-tagged)
//   data_o/ch_o/valid_o         : filtered output, one-cycle strobe
//   coef_we_i/coef_sel_i/coef_data_i/coef_commit_i : shadow write + commit
//   clear_i                     : zero histories, abort in-flight sample
// slave = filter side, master = sample source / controller side.
interface iir_biquad_tdm_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int NUM_CH = 2
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic signed [DATA_W-1:0] data_i;
  logic [CH_W-1:0]          ch_i;
  logic                     valid_i;
  logic                     ready_o;
  logic signed [DATA_W-1:0] data_o;
  logic [CH_W-1:0]          ch_o;
  logic                     valid_o;
  logic                     coef_we_i;
  logic [2:0]               coef_sel_i;
  logic signed [COEF_W-1:0] coef_data_i;
  logic                     coef_commit_i;
  logic                     clear_i;

  modport slave (
    input  data_i, ch_i, valid_i, coef_we_i, coef_sel_i, coef_data_i,
           coef_commit_i, clear_i,
    output ready_o, data_o, ch_o, valid_o
  );

  modport master (
    output data_i, ch_i, valid_i, coef_we_i, coef_sel_i, coef_data_i,
           coef_commit_i, clear_i,
    input  ready_o, data_o, ch_o, valid_o
  );
endinterface

// File: rtl/iir_biquad_tdm.sv
// iir_biquad_tdm -- direct-form-I biquad shared across NUM_CH channels with a
// single multiply-accumulate unit (one tap per cycle, 7 cycles per sample).
//   y = (b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) >>> FRAC, saturated to DATA_W.
// Ports:
//   clk_i   : clock
//   reset_i : synchronous active-high reset
//   bus     : iir_biquad_tdm_if.slave (sample in/out, coefficients, clear)
// Coefficients live in a shadow bank (written any time) and an active bank
// (used by the MAC); a commit copies shadow->active only when no sample is
// in flight, otherwise it is deferred to the end of the current sample.
module iir_biquad_tdm #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int FRAC   = 16,
  parameter int NUM_CH = 2
) (
  input logic            clk_i,
  input logic            reset_i,
  iir_biquad_tdm_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = DATA_W + COEF_W;
  localparam int AW   = DATA_W + COEF_W + 3;

  localparam logic [CH_W:0]          NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic [COEF_W-1:0]      UNITY    = COEF_W'(1) << FRAC;
  localparam logic signed [AW-1:0]   SMAX     = AW'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [AW-1:0]   SMIN     = -SMAX - AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                    state_q;
  logic [2:0]                tap_q;
  logic signed [DATA_W-1:0]  x_q;
  logic [CH_W-1:0]           ch_q;
  logic signed [AW-1:0]      acc_q;
  logic                      commit_pending_q;
  logic [4:0][COEF_W-1:0]    shadow_q, active_q;
  logic [NUM_CH-1:0][DATA_W-1:0] x1_q, x2_q, y1_q, y2_q;
  logic                      ready_q, valid_q;
  logic [DATA_W-1:0]         data_q;
  logic [CH_W-1:0]           ch_o_q;

  logic signed [COEF_W-1:0]  coef_op;
  logic signed [DATA_W-1:0]  samp_op;
  logic signed [PW-1:0]      prod;
  logic signed [AW-1:0]      prod_ext, acc_nxt, shifted;
  logic [DATA_W-1:0]         y_sat;
  logic                      accept;

  // Tap order b0,b1,b2,a1,a2; history of the channel being processed.
  always_comb begin
    coef_op = '0;
    samp_op = '0;
    case (tap_q)
      3'd0:    begin coef_op = active_q[0]; samp_op = x_q;         end
      3'd1:    begin coef_op = active_q[1]; samp_op = x1_q[ch_q];  end
      3'd2:    begin coef_op = active_q[2]; samp_op = x2_q[ch_q];  end
      3'd3:    begin coef_op = active_q[3]; samp_op = y1_q[ch_q];  end
      default: begin coef_op = active_q[4]; samp_op = y2_q[ch_q];  end
    endcase
  end

  assign prod     = coef_op * samp_op;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  // Feedback taps are subtracted.
  assign acc_nxt  = (tap_q < 3'd3) ? acc_q + prod_ext : acc_q - prod_ext;
  assign shifted  = acc_q >>> FRAC;

  always_comb begin
    y_sat = shifted[DATA_W-1:0];
    if (shifted > SMAX)      y_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < SMIN) y_sat = {1'b1, {(DATA_W-1){1'b0}}};
  end

  // Out-of-range channels are dropped without stalling the source.
  assign accept = (state_q == S_IDLE) && bus.valid_i && ({1'b0, bus.ch_i} < NUM_CH_L);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_q <= '0;
      shadow_q[0] <= UNITY;
    end else if (bus.coef_we_i && bus.coef_sel_i <= 3'd4) begin
      shadow_q[bus.coef_sel_i] <= bus.coef_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      tap_q            <= '0;
      x_q              <= '0;
      ch_q             <= '0;
      acc_q            <= '0;
      commit_pending_q <= 1'b0;
      active_q         <= '0;
      active_q[0]      <= UNITY;
      x1_q             <= '0;
      x2_q             <= '0;
      y1_q             <= '0;
      y2_q             <= '0;
      ready_q          <= 1'b1;
      valid_q          <= 1'b0;
      data_q           <= '0;
      ch_o_q           <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.clear_i) begin
        state_q <= S_IDLE;
        ready_q <= 1'b1;
        tap_q   <= '0;
        acc_q   <= '0;
        x1_q    <= '0;
        x2_q    <= '0;
        y1_q    <= '0;
        y2_q    <= '0;
        // Nothing is in flight after a clear, so a coincident commit is
        // treated like an idle commit.
        if (bus.coef_commit_i) active_q <= shadow_q;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              x_q     <= bus.data_i;
              ch_q    <= bus.ch_i;
              tap_q   <= '0;
              acc_q   <= '0;
              ready_q <= 1'b0;
              state_q <= S_MAC;
              // The accepted sample must see the old bank.
              if (bus.coef_commit_i) commit_pending_q <= 1'b1;
            end else if (bus.coef_commit_i) begin
              active_q <= shadow_q;
            end
          end
          S_MAC: begin
            acc_q <= acc_nxt;
            tap_q <= tap_q + 3'd1;
            if (tap_q == 3'd4) state_q <= S_DONE;
            if (bus.coef_commit_i) commit_pending_q <= 1'b1;
          end
          S_DONE: begin
            data_q       <= y_sat;
            ch_o_q       <= ch_q;
            valid_q      <= 1'b1;
            x2_q[ch_q]   <= x1_q[ch_q];
            x1_q[ch_q]   <= x_q;
            y2_q[ch_q]   <= y1_q[ch_q];
            y1_q[ch_q]   <= y_sat;
            if (commit_pending_q || bus.coef_commit_i) active_q <= shadow_q;
            commit_pending_q <= 1'b0;
            ready_q      <= 1'b1;
            state_q      <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.ch_o    = ch_o_q;
endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Directed bench for iir_biquad_tdm. NUM_CH=3 so that an out-of-range channel
// index (3) is representable on ch_i.
module tb_iir_biquad_tdm;
  localparam int DATA_W = 16;
  localparam int COEF_W = 18;
  localparam int FRAC   = 16;
  localparam int NUM_CH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   t_acc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iir_biquad_tdm_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_CH(NUM_CH)) bus ();

  iir_biquad_tdm #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC(FRAC), .NUM_CH(NUM_CH)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int x);
    int k = 0;
    while (!bus.ready_o && k < 20) begin tick(); k++; end
    bus.ch_i    = 2'(ch);
    bus.data_i  = 16'(x);
    bus.valid_i = 1'b1;
    tick();
    t_acc       = cyc;
    bus.valid_i = 1'b0;
    check("busy_ready_low", 32'(bus.ready_o), 0);
  endtask

  task automatic expect_out(input string tag, input int ch, input int y);
    int k = 0;
    while (!bus.valid_o && k < 20) begin tick(); k++; end
    check({tag, "_latency"}, cyc - t_acc, 6);
    check({tag, "_data"}, $signed(bus.data_o), y);
    check({tag, "_ch"}, 32'(bus.ch_o), ch);
    check({tag, "_ready_back"}, 32'(bus.ready_o), 1);
    tick();
    check({tag, "_strobe_1cyc"}, 32'(bus.valid_o), 0);
  endtask

  task automatic wcoef(input int sel, input int val);
    bus.coef_sel_i  = 3'(sel);
    bus.coef_data_i = 18'(val);
    bus.coef_we_i   = 1'b1;
    tick();
    bus.coef_we_i   = 1'b0;
  endtask

  task automatic commit();
    bus.coef_commit_i = 1'b1;
    tick();
    bus.coef_commit_i = 1'b0;
  endtask

  task automatic clear();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
  endtask

  initial begin
    int nv;
    bus.data_i = '0; bus.ch_i = '0; bus.valid_i = 1'b0;
    bus.coef_we_i = 1'b0; bus.coef_sel_i = '0; bus.coef_data_i = '0;
    bus.coef_commit_i = 1'b0; bus.clear_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_ready", 32'(bus.ready_o), 1);
    check("rst_valid", 32'(bus.valid_o), 0);
    check("rst_data", $signed(bus.data_o), 0);
    check("rst_ch", 32'(bus.ch_o), 0);

    // Identity after reset.
    push(0, 1000);   expect_out("id_1000", 0, 1000);
    push(0, -32768); expect_out("id_min", 0, -32768);
    push(2, -5);     expect_out("id_ch2", 2, -5);

    // Gain 0.5 with floor rounding.
    wcoef(0, 32768); commit();
    push(0, 1000);   expect_out("gain_pos", 0, 500);
    push(0, -1001);  expect_out("gain_floor", 0, -501);

    // y = x + 0.5*y1
    wcoef(0, 65536); wcoef(3, -32768); commit(); clear();
    push(0, 16384); expect_out("pole0", 0, 16384);
    push(0, 0);     expect_out("pole1", 0, 8192);
    push(0, 0);     expect_out("pole2", 0, 4096);
    push(0, 0);     expect_out("pole3", 0, 2048);

    // Saturation.
    wcoef(0, 131071); wcoef(3, 0); commit(); clear();
    push(0, 32767);  expect_out("sat_pos", 0, 32767);
    push(0, -32768); expect_out("sat_neg", 0, -32768);
    wcoef(3, -65536); commit(); clear();
    push(0, 20000); expect_out("sat_fb0", 0, 32767);
    push(0, 20000); expect_out("sat_fb1", 0, 32767);
    push(0, 20000); expect_out("sat_fb2", 0, 32767);

    // Channel independence, then clear mid-MAC.
    wcoef(0, 65536); wcoef(3, -32768); commit(); clear();
    push(0, 16384); expect_out("chi_a0", 0, 16384);
    push(1, 0);     expect_out("chi_b0", 1, 0);
    push(0, 0);     expect_out("chi_a1", 0, 8192);
    push(1, 0);     expect_out("chi_b1", 1, 0);
    push(0, 0);     expect_out("chi_a2", 0, 4096);
    push(0, 1234); tick(); tick(); clear();
    check("clr_ready", 32'(bus.ready_o), 1);
    nv = 0;
    repeat (12) begin if (bus.valid_o) nv++; tick(); end
    check("clr_no_valid", nv, 0);
    push(0, 0); expect_out("clr_hist0", 0, 0);

    // Deferred commit.
    wcoef(0, 65536); wcoef(3, 0); commit(); clear();
    push(0, 1000);
    wcoef(0, 32768); commit();
    expect_out("dc_old", 0, 1000);
    push(0, 1000); expect_out("dc_new", 0, 500);

    // Out-of-range channel is ignored.
    bus.ch_i = 2'd3; bus.data_i = 16'sd777; bus.valid_i = 1'b1;
    tick(); tick();
    bus.valid_i = 1'b0;
    check("badch_ready", 32'(bus.ready_o), 1);
    nv = 0;
    repeat (12) begin if (bus.valid_o) nv++; tick(); end
    check("badch_no_valid", nv, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
